boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream feeder of the CPU top. Receives a framed byte stream (UART receiver or test host) and writes the program image into CPU RAM through a dedicated write port.
- Holds the CPU in reset until a frame has been received and checksum-verified, then releases it.
- Re-arms on request so a new image can be loaded without a system reset.

Parameters:
- LOAD_BASE, 8'h00, RAM address of the first data byte; address wraps modulo 256.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes inside a frame; 0 disables the timeout.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- boot_req  input  1  single-cycle re-load request; honoured only in DONE.
- ram_wr_en  output  1  RAM write strobe, one cycle per data byte.
- ram_wr_addr  output  8  RAM write address.
- ram_wr_data  output  8  RAM write data.
- cpu_rst_n  output  1  CPU reset, active-low; low holds the CPU in reset.
- busy  output  1  high in LEN, DATA or CHK.
- done  output  1  high in DONE.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst low) sets: state SYNC, rx_ready=1, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, cpu_rst_n=0, busy=0, done=0, err=0, counters=0, checksum=0.
- All outputs are registered.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK.
  - LEN=0 means 256 bytes.
  - Valid frame condition: (sum of data bytes + CHK) mod 256 == 0.
- SYNC state:
  - rx_ready=1.
  - Accepted byte == SYNC_BYTE: go to LEN, clear err, clear checksum.
  - Any other accepted byte is discarded.
  - No timeout in SYNC.
- LEN state:
  - Accepted byte loads the remaining-count register (0 becomes 256, 9-bit counter).
  - Write address resets to LOAD_BASE; go to DATA.
- DATA state:
  - Each accepted byte: ram_wr_en=1 in the following cycle, with ram_wr_addr = current address and ram_wr_data = the byte.
  - After each accepted byte: address increments with 8-bit wrap (8'hFF to 8'h00), checksum += byte (mod 256), remaining count decrements.
  - When the count reaches 0, go to CHK.
  - Back-to-back bytes produce back-to-back write strobes.
- CHK state:
  - Accepted byte is checked against the valid-frame condition.
  - Pass: go to DONE.
  - Fail: go to ERR.
- DONE state:
  - rx_ready=0, done=1, cpu_rst_n=1 from the first cycle after entry.
  - boot_req=1: go to SYNC; cpu_rst_n=0 and done=0 on the next cycle.
- ERR state:
  - err=1 (sticky), cpu_rst_n stays 0, rx_ready=0 for exactly one cycle, then go to SYNC.
  - err stays set until the next accepted SYNC_BYTE.
- Timeout (TIMEOUT != 0):
  - Idle counter clears on every accepted byte and on every state entry.
  - Counter increments each cycle in LEN, DATA or CHK without a transfer.
  - Reaching TIMEOUT: go to ERR.
  - RAM bytes already written are not rolled back.
- Simultaneous events:
  - A transfer in the same cycle the counter would hit TIMEOUT counts as a transfer; no error.
  - boot_req outside DONE is ignored.
  - rx_valid while rx_ready=0: the byte is not consumed; the sender must hold it.
- Reset mid-frame: immediate return to reset values; the partial image is abandoned and the CPU stays in reset.
- busy and done are never high at the same time.
- cpu_rst_n is high only in DONE.

Decomposition:
- Shared params header (params.vh):
  - state encodings BL_SYNC, BL_LEN, BL_DATA, BL_CHK, BL_DONE, BL_ERR (3 bits);
  - BL_SYNC_BYTE;
  - BL_STATE_W.
- Sub-module boot_timeout: idle counter with clear, enable and a parameterised terminal compare, producing a single expired pulse.
- The FSM, address and count registers, and checksum stay in boot_loader.

Test Plan:
- Normal load:
  - Stimulus: A5, 03, 11, 22, 33, then CHK=9A, back-to-back.
  - Response: writes 11@00, 22@01, 33@02 on consecutive cycles; done=1; cpu_rst_n=1 the cycle after CHK; err=0.
- Bad checksum:
  - Stimulus: same frame with CHK=9B.
  - Response: ERR for 1 cycle, err=1, cpu_rst_n=0, return to SYNC; a later A5 clears err.
- Wrap and full length (LOAD_BASE=8'hFE):
  - Stimulus: LEN=00, 256 bytes, correct CHK.
  - Response: 256 writes, addresses FE, FF, 00 ... FD; done=1.
- Noise, backpressure and re-arm:
  - Stimulus: bytes 00, FF before A5; rx_valid gaps mid-DATA; boot_req pulsed in DONE.
  - Response: noise discarded with no writes; no write during gaps; after boot_req, cpu_rst_n=0 next cycle and rx_ready=1.
- Timeout (TIMEOUT=8):
  - Stimulus: A5, 04, one data byte, then 8 idle cycles.
  - Response: err=1 on the 8th idle cycle.
  - Variant: a byte arriving exactly on cycle 8 is accepted with no error.
- Async reset mid-DATA:
  - Stimulus: drive rst low between clock edges.
  - Response: outputs take reset values immediately (cpu_rst_n=0, ram_wr_en=0); after release, the loader waits for A5.

Source files
------------

// File: rtl/boot_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : boot_loader_pkg                                            |
// | Brief   : Shared state encodings, constants and helpers for the      |
// |           framed-image boot loader.                                  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package boot_loader_pkg;

  localparam int         BL_STATE_W   = 3;
  localparam logic [7:0] BL_SYNC_BYTE = 8'hA5;

  typedef enum logic [BL_STATE_W-1:0] {
    BL_SYNC = 3'd0,
    BL_LEN  = 3'd1,
    BL_DATA = 3'd2,
    BL_CHK  = 3'd3,
    BL_DONE = 3'd4,
    BL_ERR  = 3'd5
  } bl_state_e;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] bl_len_count(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

  // States in which a frame is in flight and the idle timer runs.
  function automatic logic bl_is_busy(input bl_state_e s);
    return (s == BL_LEN) || (s == BL_DATA) || (s == BL_CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/boot_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : boot_timeout                                               |
// | Brief   : Idle-cycle counter with clear/enable; raises a one-cycle   |
// |           expired pulse on the cycle the count reaches TIMEOUT.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module boot_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int unsigned      CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Clear wins over counting; the count holds the number of idle cycles so far.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Idle counter register.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // This idle cycle would be the TIMEOUT-th one.
      assign expired = en && (cnt_q == LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : boot_loader                                                |
// | Brief   : Receives SYNC/LEN/DATA/CHK frames, writes the image into   |
// |           CPU RAM and releases CPU reset once the checksum verifies. |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0]  LOAD_BASE = 8'h00,
  parameter int unsigned TIMEOUT   = 1024,
  parameter logic [7:0]  SYNC_BYTE = BL_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic       boot_req,
  output logic       ram_wr_en,
  output logic [7:0] ram_wr_addr,
  output logic [7:0] ram_wr_data,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  bl_state_e  state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [8:0] count_q, count_d;
  logic [7:0] csum_q, csum_d;
  logic       rx_ready_q, rx_ready_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       cpu_rst_n_q, cpu_rst_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       xfer;
  logic [7:0] chk_sum;
  logic       tmo_en;
  logic       tmo_clr;
  logic       tmo_expired;

  // rx_ready is registered, so a transfer is judged against its current value.
  assign xfer    = rx_valid && rx_ready_q;
  assign chk_sum = csum_q + rx_data;
  assign tmo_en  = bl_is_busy(state_q) && !xfer;
  assign tmo_clr = xfer || (state_d != state_q);

  boot_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;

    case (state_q)
      BL_SYNC: begin
        if (xfer && (rx_data == SYNC_BYTE)) begin
          state_d = BL_LEN;
          err_d   = 1'b0;
          csum_d  = 8'd0;
        end
      end
      BL_LEN: begin
        if (xfer) begin
          count_d = bl_len_count(rx_data);
          addr_d  = LOAD_BASE;
          state_d = BL_DATA;
        end else if (tmo_expired) begin
          state_d = BL_ERR;
        end
      end
      BL_DATA: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          addr_d    = addr_q + 8'd1;
          csum_d    = chk_sum;
          count_d   = count_q - 9'd1;
          if (count_q == 9'd1) begin
            state_d = BL_CHK;
          end
        end else if (tmo_expired) begin
          state_d = BL_ERR;
        end
      end
      BL_CHK: begin
        if (xfer) begin
          state_d = (chk_sum == 8'd0) ? BL_DONE : BL_ERR;
        end else if (tmo_expired) begin
          state_d = BL_ERR;
        end
      end
      BL_DONE: begin
        if (boot_req) begin
          state_d = BL_SYNC;
        end
      end
      BL_ERR: begin
        state_d = BL_SYNC;
      end
      default: begin
        state_d = BL_SYNC;
      end
    endcase

    if (state_d == BL_ERR) begin
      err_d = 1'b1;
    end

    rx_ready_d  = (state_d != BL_DONE) && (state_d != BL_ERR);
    cpu_rst_n_d = (state_d == BL_DONE);
    done_d      = (state_d == BL_DONE);
    busy_d      = bl_is_busy(state_d);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BL_SYNC;
      addr_q      <= 8'd0;
      count_q     <= 9'd0;
      csum_q      <= 8'd0;
      rx_ready_q  <= 1'b1;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      csum_q      <= csum_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_ready    = rx_ready_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_boot_loader                                             |
// | Brief   : Self-checking bench for boot_loader with a frame-level     |
// |           reference model (image layout, checksum, timeout).         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_boot_loader;

  localparam int BASE = 254;
  localparam int TMO  = 8;

  typedef logic [7:0] bq_t [$];
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] rx_data  = 8'd0;
  logic       rx_valid = 1'b0;
  logic       boot_req = 1'b0;
  logic       rx_ready;
  logic       ram_wr_en;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;

  int  total  = 0;
  int  passed = 0;
  int  failed = 0;
  int  cyc    = 0;
  wr_t wr_q [$];

  boot_loader #(
    .LOAD_BASE (8'hFE),
    .TIMEOUT   (TMO),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .boot_req    (boot_req),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .cpu_rst_n   (cpu_rst_n),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every RAM write strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (rst && ram_wr_en) wr_q.push_back('{ram_wr_addr, ram_wr_data, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: summary not reached (observed timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_status(input string tag, input bit rdy, input bit dn,
                               input bit cr, input bit bs, input bit er);
    check({tag, ".rx_ready"},  rx_ready,  rdy);
    check({tag, ".done"},      done,      dn);
    check({tag, ".cpu_rst_n"}, cpu_rst_n, cr);
    check({tag, ".busy"},      busy,      bs);
    check({tag, ".err"},       err,       er);
  endtask

  function automatic int pick(input int gap);
    return (gap < 0) ? int'($urandom_range(0, TMO - 2)) : gap;
  endfunction

  // Present one byte after `gap` idle cycles; returns on the negedge after acceptance.
  task automatic send(input logic [7:0] b, input int gap);
    bit accepted;
    int n;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    accepted = 1'b0;
    while (!accepted && n < 40) begin
      accepted = rx_ready;
      @(negedge clk);
      n++;
    end
    rx_valid = 1'b0;
    check("accept", accepted, 1'b1);
  endtask

  // Send one complete frame and compare outcome and RAM writes with the model.
  task automatic frame(input string tag, input logic [7:0] lenb, input bq_t data,
                       input logic [7:0] chk, input int gap);
    int sum;
    bit good;
    wr_q.delete();
    sum = int'(chk);
    foreach (data[i]) sum += int'(data[i]);
    good = ((sum % 256) == 0);
    send(8'hA5, pick(gap));
    send(lenb, pick(gap));
    foreach (data[i]) send(data[i], pick(gap));
    send(chk, pick(gap));
    if (good) expect_status({tag, ".end"}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    else      expect_status({tag, ".end"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check({tag, ".wr_count"}, wr_q.size(), data.size());
    for (int i = 0; i < data.size() && i < wr_q.size(); i++) begin
      check({tag, ".wr_addr"}, wr_q[i].a, (BASE + i) % 256);
      check({tag, ".wr_data"}, wr_q[i].d, data[i]);
      if (gap == 0) check({tag, ".wr_b2b"}, wr_q[i].c, wr_q[0].c + i);
    end
    wr_q.delete();
    if (good) begin
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
      expect_status({tag, ".rearm"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      @(negedge clk);
      expect_status({tag, ".recover"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  function automatic logic [7:0] good_chk(input bq_t data);
    int sum;
    sum = 0;
    foreach (data[i]) sum += int'(data[i]);
    return 8'((256 - (sum % 256)) % 256);
  endfunction

  initial begin
    bq_t q;
    int  n;
    logic [7:0] c;

    // Reset values while rst is held low.
    repeat (3) @(negedge clk);
    expect_status("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.wr_en",   ram_wr_en,   1'b0);
    check("reset.wr_addr", ram_wr_addr, 8'h00);
    check("reset.wr_data", ram_wr_data, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // boot_req outside DONE has no effect.
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    expect_status("bootreq_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Noise before the sync byte is discarded.
    wr_q.delete();
    send(8'h00, 0);
    send(8'hFF, 0);
    @(negedge clk);
    check("noise.busy", busy, 1'b0);
    check("noise.writes", wr_q.size(), 0);

    // Directed normal load and bad checksum.
    q = '{8'h11, 8'h22, 8'h33};
    frame("normal", 8'h03, q, 8'h9A, 0);
    frame("badchk", 8'h03, q, 8'h9B, 0);

    // A fresh sync byte clears the sticky error.
    send(8'hA5, 0);
    check("resync.err", err, 1'b0);
    check("resync.busy", busy, 1'b1);
    send(8'h01, 0);
    send(8'h5A, 0);
    send(8'hA6, 0);
    expect_status("resync.end", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;

    // Random frames with noise, random gaps and random checksum validity.
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'hA5) c = 8'h5A;
        send(c, int'($urandom_range(0, 2)));
      end
      q = {};
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      c = good_chk(q);
      if ($urandom_range(0, 2) == 0) c = c + 8'($urandom_range(1, 255));
      frame("random", 8'(n), q, c, ($urandom_range(0, 1) == 0) ? 0 : -1);
    end

    // Every byte arrives on the last permitted idle cycle: no timeout.
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(0, 255)));
    frame("tmo_edge", 8'd4, q, good_chk(q), TMO - 1);

    // Timeout after one data byte; the written byte stays.
    wr_q.delete();
    send(8'hA5, 0);
    send(8'h04, 0);
    send(8'h3C, 0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo.idle7.err", err, 1'b0);
    check("tmo.idle7.busy", busy, 1'b1);
    @(negedge clk);
    expect_status("tmo.expired", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("tmo.kept_count", wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check("tmo.kept_addr", wr_q[0].a, 8'hFE);
      check("tmo.kept_data", wr_q[0].d, 8'h3C);
    end
    @(negedge clk);
    expect_status("tmo.resync", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full 256-byte image wrapping through address FF -> 00.
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(8'($urandom_range(0, 255)));
    frame("full", 8'h00, q, good_chk(q), 0);

    // Asynchronous reset between clock edges in the middle of DATA.
    send(8'hA5, 0);
    send(8'd10, 0);
    send(8'h01, 0);
    send(8'h02, 0);
    check("arst.pre_wr_en", ram_wr_en, 1'b1);
    #2 rst = 1'b0;
    #1;
    expect_status("arst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst.wr_en",   ram_wr_en,   1'b0);
    check("arst.wr_addr", ram_wr_addr, 8'h00);
    check("arst.wr_data", ram_wr_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    wr_q.delete();
    send(8'h01, 0);
    send(8'h05, 0);
    repeat (2) @(negedge clk);
    check("arst.wait_sync.busy", busy, 1'b0);
    check("arst.wait_sync.writes", wr_q.size(), 0);
    q = '{8'h10, 8'h20};
    frame("arst.reload", 8'h02, q, good_chk(q), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
